// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the response-owner encoding, grant vector bit positions and
// default parameter values used by mem_port_arbiter and mem_port_prio.
package mem_port_arbiter_pkg;

   // Response owner register encoding
   typedef logic [1:0] owner_t;
   localparam owner_t OWN_NONE  = 2'd0;
   localparam owner_t OWN_I     = 2'd1;
   localparam owner_t OWN_D_RD  = 2'd2;
   localparam owner_t OWN_D_ERR = 2'd3;

   // Bit positions inside the one-hot grant vector
   localparam int unsigned GNT_I = 0;
   localparam int unsigned GNT_D = 1;

   // Default parameter values
   localparam int unsigned ADD_WIDTH_DEF  = 18;
   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned STARVE_CNT_W   = 4;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_prio.sv
// Combinational winner select for the memory port arbiter.
// Ports:
//   i_req  - instruction fetch request (already qualified by reset)
//   d_req  - data request (already qualified by reset)
//   starve - instruction fetch has been blocked long enough and must win
//   gnt_c  - one-hot grant vector, bit GNT_I / GNT_D
module mem_port_prio
   import mem_port_arbiter_pkg::*;
(
   input  logic       i_req,
   input  logic       d_req,
   input  logic       starve,
   output logic [1:0] gnt_c
);

   // Data wins conflicts unless instruction fetch is starved
   always_comb begin
      gnt_c = 2'b00;
      if (i_req && (!d_req || starve)) begin
         gnt_c[GNT_I] = 1'b1;
      end else if (d_req) begin
         gnt_c[GNT_D] = 1'b1;
      end
   end

endmodule : mem_port_prio

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read memory between instruction
// fetch and load/store. One grant per cycle, read data returned one
// cycle after the grant on the owning requester's response port.
// Ports:
//   clk, reset                 - clock, synchronous active-low reset
//   i_req/i_addr/i_gnt         - instruction request handshake
//   i_rvalid/i_rdata           - instruction read response
//   d_req/d_addr/d_wen/d_wdata - data request (d_wen == 0 is a read)
//   d_gnt                      - data grant
//   d_rvalid/d_rdata/d_err     - data read / error response
//   m_addr/m_wen/m_wdata       - memory request
//   m_rdata                    - memory read data, one cycle after m_addr
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_wen,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] m_addr,
   output logic [3:0]  m_wen,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADD_WIDTH) - 64'd1);
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] starve_cnt;
   owner_t                  owner;
   owner_t                  owner_nxt_c;
   logic [1:0]              gnt_c;
   logic                    i_req_q_c;
   logic                    d_req_q_c;
   logic                    starve_c;
   logic                    d_legal_c;

   // No grants are issued while reset is held
   assign i_req_q_c = i_req & reset;
   assign d_req_q_c = d_req & reset;
   assign starve_c  = (starve_cnt == STARVE_LIM);
   assign d_legal_c = ((d_addr >> ADD_WIDTH) == 32'd0);

   mem_port_prio u_prio (
      .i_req  (i_req_q_c),
      .d_req  (d_req_q_c),
      .starve (starve_c),
      .gnt_c  (gnt_c)
   );

   assign i_gnt = gnt_c[GNT_I];
   assign d_gnt = gnt_c[GNT_D];

   // Memory drive; instruction addresses wrap, illegal data accesses never write
   always_comb begin
      m_addr  = 32'd0;
      m_wen   = 4'd0;
      m_wdata = 32'd0;
      if (i_gnt) begin
         m_addr  = i_addr & ADDR_MASK;
         m_wdata = d_wdata;
      end else if (d_gnt) begin
         m_addr  = d_addr;
         m_wdata = d_wdata;
         if (d_legal_c) begin
            m_wen = d_wen;
         end
      end
   end

   // Who owns the response slot in the next cycle
   always_comb begin
      owner_nxt_c = OWN_NONE;
      if (i_gnt) begin
         owner_nxt_c = OWN_I;
      end else if (d_gnt) begin
         if (!d_legal_c) begin
            owner_nxt_c = OWN_D_ERR;
         end else if (d_wen == 4'd0) begin
            owner_nxt_c = OWN_D_RD;
         end
      end
   end

   // Owner register and starvation counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         owner <= owner_nxt_c;
         if (i_gnt || !i_req) begin
            starve_cnt <= '0;
         end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
         end
      end
   end

   // Response ports: memory data is steered to the owner, zero otherwise
   assign i_rvalid = (owner == OWN_I);
   assign i_rdata  = (owner == OWN_I) ? m_rdata : 32'd0;
   assign d_rvalid = (owner == OWN_D_RD) || (owner == OWN_D_ERR);
   assign d_err    = (owner == OWN_D_ERR);
   assign d_rdata  = (owner == OWN_D_RD) ? m_rdata : 32'd0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 18;
   localparam int unsigned SMAX = 4;
   localparam longint unsigned SPAN = 64'd1 << AW;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_wen;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] m_addr;
   logic [3:0]  m_wen;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADD_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   function automatic logic [31:0] init_word(int unsigned idx);
      return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
   endfunction

   // Backing memory device: synchronous read, byte-enabled write
   logic [31:0]  dev_mem [int unsigned];
   int unsigned  dev_idx;
   logic [31:0]  dev_w;
   always @(posedge clk) begin
      dev_idx = 32'(m_addr[AW-1:2]);
      dev_w   = dev_mem.exists(dev_idx) ? dev_mem[dev_idx] : init_word(dev_idx);
      m_rdata <= dev_w;
      if (m_wen != 4'd0) begin
         for (int b = 0; b < 4; b++)
            if (m_wen[b]) dev_w[8*b +: 8] = m_wdata[8*b +: 8];
         dev_mem[dev_idx] = dev_w;
      end
   end

   // Reference model: word store, starvation streak, pending response
   logic [31:0] ref_mem [int unsigned];
   int unsigned streak = 0;
   logic        e_iv = 1'b0, e_dv = 1'b0, e_de = 1'b0;
   logic [31:0] e_id = 32'd0, e_dd = 32'd0;

   function automatic int unsigned word_of(logic [31:0] a);
      return 32'((64'(a) % SPAN) / 64'd4);
   endfunction

   function automatic logic legal(logic [31:0] a);
      return 64'(a) < SPAN;
   endfunction

   function automatic logic [31:0] ref_read(logic [31:0] a);
      int unsigned k = word_of(a);
      return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
   endfunction

   // Expected grant {d, i} for the current inputs
   function automatic logic [1:0] model_pick();
      if (!reset) return 2'b00;
      if (i_req && d_req) return (streak == SMAX) ? 2'b01 : 2'b10;
      if (i_req) return 2'b01;
      if (d_req) return 2'b10;
      return 2'b00;
   endfunction

   // Clock edge: advance the reference model with the inputs held across it
   task automatic advance();
      logic [1:0]  g;
      logic [31:0] w;
      int unsigned k;
      g = model_pick();
      @(posedge clk);
      e_iv = 1'b0; e_dv = 1'b0; e_de = 1'b0; e_id = 32'd0; e_dd = 32'd0;
      if (!reset) begin
         streak = 0;
      end else begin
         if (g[0]) begin
            e_iv = 1'b1;
            e_id = ref_read(i_addr);
         end else if (g[1]) begin
            if (!legal(d_addr)) begin
               e_dv = 1'b1;
               e_de = 1'b1;
            end else if (d_wen == 4'd0) begin
               e_dv = 1'b1;
               e_dd = ref_read(d_addr);
            end else begin
               k = word_of(d_addr);
               w = ref_read(d_addr);
               for (int b = 0; b < 4; b++)
                  if (d_wen[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
               ref_mem[k] = w;
            end
         end
         if (!i_req || g[0]) streak = 0;
         else if (g[1] && streak < SMAX) streak = streak + 1;
      end
      #1;
   endtask

   task automatic idle();
      i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_addr = 32'd0; d_wen = 4'd0; d_wdata = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_addr = 32'h24; d_wen = 4'hF; d_wdata = 32'hFFFF_FFFF;
      advance();
      advance();
      @(negedge clk);
      checks++;
      if ({i_gnt, d_gnt, m_wen} !== 6'd0) begin
         errors++;
         $display("FAIL reset_gnt got i_gnt=%b d_gnt=%b m_wen=%h exp 0", i_gnt, d_gnt, m_wen);
      end
      checks++;
      if ({i_rvalid, d_rvalid, d_err, i_rdata, d_rdata} !== 67'd0) begin
         errors++;
         $display("FAIL reset_resp got iv=%b dv=%b de=%b ird=%h drd=%h exp all 0",
                  i_rvalid, d_rvalid, d_err, i_rdata, d_rdata);
      end
      advance();
      reset = 1'b1;
      idle();
      advance();
   endtask

   task automatic test_single_read();
      d_req = 1'b1; d_addr = 32'h10; d_wen = 4'hF; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if ({d_gnt, m_wen} !== {1'b1, 4'hF}) begin
         errors++;
         $display("FAIL preload_write got d_gnt=%b m_wen=%h exp 1 f", d_gnt, m_wen);
      end
      advance();
      idle();
      i_req = 1'b1; i_addr = 32'h10;
      @(negedge clk);
      checks++;
      if ({i_gnt, d_gnt, d_rvalid, m_addr} !== {3'b100, 32'h10}) begin
         errors++;
         $display("FAIL ifetch_grant got i_gnt=%b d_gnt=%b d_rvalid=%b m_addr=%h exp 1 0 0 10",
                  i_gnt, d_gnt, d_rvalid, m_addr);
      end
      advance();
      idle();
      @(negedge clk);
      checks++;
      if ({i_rvalid, i_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL ifetch_data got v=%b d=%h exp 1 deadbeef", i_rvalid, i_rdata);
      end
      advance();
   endtask

   task automatic test_starvation();
      logic [1:0] exp_g;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_addr = 32'h200; d_wen = 4'd0;
      for (int k = 0; k < 15; k++) begin
         exp_g = ((k % 5) == 4) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if ({d_gnt, i_gnt} !== exp_g) begin
            errors++;
            $display("FAIL starve_pattern cycle %0d got d=%b i=%b exp d=%b i=%b",
                     k, d_gnt, i_gnt, exp_g[1], exp_g[0]);
         end
         advance();
      end
      idle();
      advance();
   endtask

   task automatic test_write_merge();
      d_req = 1'b1; d_addr = 32'h40; d_wen = 4'hF; d_wdata = 32'hAAAA_AAAA;
      advance();
      d_wen = 4'b0011; d_wdata = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if ({d_gnt, d_rvalid, m_wen} !== {2'b10, 4'b0011}) begin
         errors++;
         $display("FAIL partial_write got d_gnt=%b d_rvalid=%b m_wen=%b exp 1 0 0011",
                  d_gnt, d_rvalid, m_wen);
      end
      advance();
      d_wen = 4'd0; d_wdata = 32'd0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL write_no_resp got d_rvalid=%b exp 0", d_rvalid);
      end
      advance();
      idle();
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hAAAA_5678}) begin
         errors++;
         $display("FAIL merge_read got v=%b e=%b d=%h exp 1 0 aaaa5678", d_rvalid, d_err, d_rdata);
      end
      advance();
   endtask

   task automatic test_illegal();
      logic [31:0] exp0;
      d_req = 1'b1; d_addr = 32'h0004_0000; d_wen = 4'd0;
      @(negedge clk);
      checks++;
      if ({d_gnt, m_wen} !== {1'b1, 4'h0}) begin
         errors++;
         $display("FAIL illegal_rd_grant got d_gnt=%b m_wen=%h exp 1 0", d_gnt, m_wen);
      end
      advance();
      d_wen = 4'hF; d_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'd0}) begin
         errors++;
         $display("FAIL illegal_rd_resp got v=%b e=%b d=%h exp 1 1 0", d_rvalid, d_err, d_rdata);
      end
      checks++;
      if ({d_gnt, m_wen} !== {1'b1, 4'h0}) begin
         errors++;
         $display("FAIL illegal_wr_wen got d_gnt=%b m_wen=%h exp 1 0", d_gnt, m_wen);
      end
      advance();
      d_addr = 32'h0; d_wen = 4'd0; d_wdata = 32'd0;
      exp0 = ref_read(32'h0);
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_err} !== 2'b11) begin
         errors++;
         $display("FAIL illegal_wr_resp got v=%b e=%b exp 1 1", d_rvalid, d_err);
      end
      advance();
      idle();
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_err, d_rdata} !== {2'b10, exp0}) begin
         errors++;
         $display("FAIL mem_unchanged got v=%b e=%b d=%h exp 1 0 %h", d_rvalid, d_err, d_rdata, exp0);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      d_req = 1'b1; d_addr = 32'h40; d_wen = 4'd0;
      advance();
      d_addr = 32'h10;
      @(negedge clk);
      checks++;
      if ({d_gnt, d_rvalid, d_rdata} !== {2'b11, 32'hAAAA_5678}) begin
         errors++;
         $display("FAIL b2b_first got gnt=%b v=%b d=%h exp 1 1 aaaa5678", d_gnt, d_rvalid, d_rdata);
      end
      advance();
      idle();
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL b2b_second got v=%b d=%h exp 1 deadbeef", d_rvalid, d_rdata);
      end
      advance();
   endtask

   task automatic test_reset_inflight();
      i_req = 1'b1; i_addr = 32'h80;
      d_req = 1'b1; d_addr = 32'h84; d_wen = 4'd0;
      for (int k = 0; k < 4; k++) advance();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({i_gnt, d_gnt, m_wen} !== 6'd0) begin
         errors++;
         $display("FAIL inflight_gnt got i=%b d=%b wen=%h exp 0", i_gnt, d_gnt, m_wen);
      end
      advance();
      reset = 1'b1;
      idle();
      @(negedge clk);
      checks++;
      if ({i_rvalid, d_rvalid, d_err, i_rdata, d_rdata} !== 67'd0) begin
         errors++;
         $display("FAIL inflight_drop got iv=%b dv=%b de=%b ird=%h drd=%h exp all 0",
                  i_rvalid, d_rvalid, d_err, i_rdata, d_rdata);
      end
      advance();
      i_req = 1'b1; i_addr = 32'h80;
      d_req = 1'b1; d_addr = 32'h84;
      @(negedge clk);
      checks++;
      if ({d_gnt, i_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL starve_cleared got d=%b i=%b exp d=1 i=0", d_gnt, i_gnt);
      end
      advance();
      idle();
      advance();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 16383)) << AW);
      return a;
   endfunction

   task automatic test_random();
      logic [1:0]  g;
      logic [3:0]  exp_wen;
      logic [31:0] exp_addr;
      int          bad;
      idle();
      for (int n = 0; n < 500; n++) begin
         if (!i_req) begin
            i_req  = 1'($urandom_range(0, 1));
            i_addr = rand_addr();
         end
         if (!d_req) begin
            d_req   = 1'($urandom_range(0, 1));
            d_addr  = rand_addr();
            d_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            d_wdata = $urandom;
         end
         g = model_pick();
         exp_wen  = (g[1] && legal(d_addr)) ? d_wen : 4'd0;
         exp_addr = g[0] ? 32'(64'(i_addr) % SPAN) : (g[1] ? d_addr : 32'd0);
         @(negedge clk);
         bad = 0;
         checks++;
         if ({d_gnt, i_gnt, m_wen, m_addr} !== {g, exp_wen, exp_addr}) begin
            errors++; bad = 1;
            $display("FAIL rand_issue cyc %0d got gnt=%b%b wen=%h addr=%h exp gnt=%b wen=%h addr=%h",
                     n, d_gnt, i_gnt, m_wen, m_addr, g, exp_wen, exp_addr);
         end
         checks++;
         if ({i_rvalid, i_rdata, d_rvalid, d_err, d_rdata} !== {e_iv, e_id, e_dv, e_de, e_dd}) begin
            errors++; bad = 1;
            $display("FAIL rand_resp cyc %0d got iv=%b id=%h dv=%b de=%b dd=%h exp iv=%b id=%h dv=%b de=%b dd=%h",
                     n, i_rvalid, i_rdata, d_rvalid, d_err, d_rdata, e_iv, e_id, e_dv, e_de, e_dd);
         end
         if (bad != 0 && errors > 20) break;
         advance();
         if (g[0]) i_req = 1'b0;
         if (g[1]) d_req = 1'b0;
      end
      idle();
      advance();
   endtask

   initial begin
      reset = 1'b0;
      idle();
      advance();
      test_reset();
      test_single_read();
      test_starvation();
      test_write_merge();
      test_illegal();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, word-addressed synchronous-read memory between the instruction-fetch path and the load/store path of the RISC-V core. Each requester uses a req/gnt handshake. Accepted reads return their data one cycle later on that requester's response port. Data accesses normally win conflicts; a starvation counter bounds how long instruction fetch can be blocked.

## Interface
Parameters:
- ADD_WIDTH, 18, byte-address width of the backing memory; a legal address has all bits ≥ ADD_WIDTH equal to zero
- STARVE_MAX, 4, number of consecutive conflict cycles won by data before instruction fetch is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_req  in  1  instruction read request; held until granted
- i_addr  in  32  instruction byte address
- i_gnt  out  1  instruction request accepted this cycle (combinational)
- i_rvalid  out  1  instruction read data valid
- i_rdata  out  32  instruction read data
- d_req  in  1  data request; held until granted
- d_addr  in  32  data byte address
- d_wen  in  4  byte write enables; 4'b0000 means read
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read response valid (reads and errors only)
- d_rdata  out  32  data read data
- d_err  out  1  with d_rvalid: address out of range
- m_addr  out  32  memory byte address; bits [ADD_WIDTH-1:2] are used
- m_wen  out  4  memory byte write enables
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data; valid the cycle after m_addr is presented

## Operation
- At most one grant per cycle. Issue is pipelined, so a new grant is allowed every cycle.
- Winner selection, when only one requester is active: that requester wins.
- Winner selection, when both are active: data wins, unless starve_cnt == STARVE_MAX; in that case instruction wins.
- starve_cnt (4 bits):
  - Increments when d_gnt=1 and i_req=1.
  - Clears when i_gnt=1 or i_req=0.
  - Saturates at STARVE_MAX.
- Illegal data address (d_addr[31:ADD_WIDTH] != 0):
  - Still granted.
  - Memory is not touched (m_wen=0).
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- Illegal instruction address: the upper bits are ignored and the address wraps modulo 2**ADD_WIDTH.
- Memory drive in a grant cycle: m_addr = winner address; m_wen = d_wen for a legal data grant, else 0; m_wdata = d_wdata.
- Memory drive with no grant: m_addr=0, m_wen=0, m_wdata=0.
- Response owner register, captured every cycle, one of: NONE, I, D_RD, D_ERR.
  - Owner I: i_rvalid=1, i_rdata=m_rdata.
  - Owner D_RD: d_rvalid=1, d_rdata=m_rdata.
  - A data write grants owner NONE. The write completes at the grant edge and no response is issued.
- Requesters must accept responses unconditionally; there is no response backpressure.
- When no response is active, i_rdata and d_rdata read 0.

## Timing
- Grant: combinational in cycle T from req and starve_cnt.
- Read latency: the response appears in cycle T+1, exactly one cycle after the grant.
- Back-to-back: grants in cycles T and T+1 produce responses in T+1 and T+2 with no bubble.
- Reset while reset=0 at a clk edge:
  - owner becomes NONE, starve_cnt becomes 0.
  - All rvalid, d_err and rdata outputs are 0 from the next cycle.
  - i_gnt=0 and d_gnt=0 combinationally while reset=0; m_wen=0.
  - An in-flight response is dropped.
- Simultaneous requests with the counter at its limit: the instruction grant clears starve_cnt in the same edge.

## Structure
- Shared package holds:
  - Owner encoding localparams: NONE=2'd0, I=2'd1, D_RD=2'd2, D_ERR=2'd3.
  - Default STARVE_MAX.
- Natural sub-module: mem_port_prio, the combinational winner select (inputs: reqs, starve flag; outputs: one-hot grant).
- Owner register and counter live in the top level.

## Test plan
- Only i_req=1 with i_addr=0x10, mem word 4 = 0xDEADBEEF → i_gnt=1 in T; i_rvalid=1 and i_rdata=0xDEADBEEF in T+1.
- Both requesters held continuously with STARVE_MAX=4 → grant pattern D,D,D,D,I repeating; starve_cnt returns to 0 after each I grant.
- Data write d_wen=4'b0011, d_wdata=0x12345678 to a word holding 0xAAAAAAAA, followed by a read of the same word → no d_rvalid for the write; the read returns 0xAAAA5678.
- d_addr=0x0004_0000 with ADD_WIDTH=18 → d_gnt=1 and m_wen=0; in T+1: d_rvalid=1, d_err=1, d_rdata=0; memory unchanged.
- Data reads granted in back-to-back cycles T and T+1 → d_rvalid high in T+1 and T+2 with the correct words.
- reset driven 0 in the cycle after a read grant → no rvalid in the following cycle; all outputs 0; starve_cnt=0.
